// File: rtl/key_pkg.sv
// Shared definitions for the multi-channel key conditioner: per-channel FSM
// encoding and default timing constants for a 50 MHz system clock.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_FILT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_FILT = 2'd3
  } key_fsm_e;

  // 20 ms debounce window and 1 s long-press threshold at 50 MHz
  localparam int               DEF_CNT_W    = 20;
  localparam int               DEF_LONG_W   = 26;
  localparam logic [19:0]      DEF_CNT_MAX  = 20'd999_999;
  localparam logic [25:0]      DEF_LONG_MAX = 26'd49_999_999;

endpackage

// File: rtl/key_debounce_ch.sv
// Single key channel: 2-FF synchroniser, debounce FSM with filter and hold
// counters, and registered press / release / long-press pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int                CNT_W      = DEF_CNT_W,
  parameter logic [CNT_W-1:0]  CNT_MAX    = DEF_CNT_MAX,
  parameter int                LONG_W     = DEF_LONG_W,
  parameter logic [LONG_W-1:0] LONG_MAX   = DEF_LONG_MAX,
  parameter bit                ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic press_flag,
  output logic release_flag,
  output logic long_flag,
  output logic key_state,
  output logic press_next
);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LONG_W-1:0] LONG_ZERO = {LONG_W{1'b0}};
  localparam logic [LONG_W-1:0] LONG_ONE  = {{(LONG_W-1){1'b0}}, 1'b1};
  localparam logic              PIN_IDLE  = ACTIVE_LOW;

  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  key_fsm_e          state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LONG_W-1:0] hold_q, hold_d;
  logic              press_q, press_d, release_q, release_d;
  logic              long_q, long_d, level_q, level_d;
  logic              act_s;

  assign act_s = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    sync1_d   = key_in;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    level_d   = level_q;
    case (state_q)
      IDLE: begin
        if (act_s) begin
          state_d = PRESS_FILT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      PRESS_FILT: begin
        if (!act_s) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX - CNT_ONE) begin
          state_d = HELD;
          press_d = 1'b1;
          level_d = 1'b1;
          cnt_d   = CNT_ZERO;
          hold_d  = LONG_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        // hold saturates at LONG_MAX so an indefinite hold never re-fires
        if (!act_s) begin
          state_d = RELEASE_FILT;
          cnt_d   = CNT_ONE;
        end else if (hold_q != LONG_MAX) begin
          hold_d  = hold_q + LONG_ONE;
          long_d  = (LONG_MAX != LONG_ZERO) && (hold_q == LONG_MAX - LONG_ONE);
        end else begin
          hold_d  = hold_q;
        end
      end
      RELEASE_FILT: begin
        if (act_s) begin
          state_d   = HELD;
          cnt_d     = CNT_ZERO;
        end else if (cnt_q == CNT_MAX - CNT_ONE) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
          cnt_d     = CNT_ZERO;
        end else begin
          cnt_d     = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
        hold_d  = LONG_ZERO;
        level_d = 1'b0;
      end
    endcase
  end

  // Channel state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= PIN_IDLE;
      sync2_q   <= PIN_IDLE;
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      hold_q    <= LONG_ZERO;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      level_q   <= level_d;
    end
  end

  assign press_flag   = press_q;
  assign release_flag = release_q;
  assign long_flag    = long_q;
  assign key_state    = level_q;
  assign press_next   = press_d;

endmodule

// File: rtl/key_debounce_multi.sv
// NUM_KEYS independent debounce channels plus a registered any_press that
// rises in the same cycle as the press_flag bits it summarises.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int                NUM_KEYS   = 4,
  parameter int                CNT_W      = DEF_CNT_W,
  parameter logic [CNT_W-1:0]  CNT_MAX    = DEF_CNT_MAX,
  parameter int                LONG_W     = DEF_LONG_W,
  parameter logic [LONG_W-1:0] LONG_MAX   = DEF_LONG_MAX,
  parameter bit                ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] press_flag,
  output logic [NUM_KEYS-1:0] release_flag,
  output logic [NUM_KEYS-1:0] long_flag,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                any_press
);

  logic [NUM_KEYS-1:0] press_next_s;
  logic                any_press_q, any_press_d;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .CNT_W      (CNT_W),
      .CNT_MAX    (CNT_MAX),
      .LONG_W     (LONG_W),
      .LONG_MAX   (LONG_MAX),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_in       (key_in[g]),
      .press_flag   (press_flag[g]),
      .release_flag (release_flag[g]),
      .long_flag    (long_flag[g]),
      .key_state    (key_state[g]),
      .press_next   (press_next_s[g])
    );
  end

  // OR the channels' next-cycle press so any_press aligns with press_flag
  always_comb begin
    any_press_d = |press_next_s;
  end

  // any_press register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= any_press_d;
    end
  end

  assign any_press = any_press_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with a cycle-level behavioural model
// of accept/reject rules, compared on every falling edge.
module tb_key_debounce_multi;

  localparam int NK = 4;
  localparam int CM = 4;
  localparam int LM = 10;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] press_flag, release_flag, long_flag, key_state;
  logic          any_press;

  always #5 clk = ~clk;

  key_debounce_multi #(
    .NUM_KEYS   (NK),
    .CNT_W      (8),
    .CNT_MAX    (8'd4),
    .LONG_W     (8),
    .LONG_MAX   (8'd10),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .press_flag   (press_flag),
    .release_flag (release_flag),
    .long_flag    (long_flag),
    .key_state    (key_state),
    .any_press    (any_press)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: a pressed/released decision flips only after CM consecutive
  // synchronised samples disagreeing with it; samples reach the decision
  // two edges after the pin is sampled.
  bit            h1 [NK];
  bit            h2 [NK];
  bit            pressed [NK];
  int            run [NK];
  int            hold [NK];
  logic [NK-1:0] exp_press = '0, exp_release = '0, exp_long = '0, exp_state = '0;
  logic          exp_any = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NK; i++) begin
        h1[i] = 1'b0; h2[i] = 1'b0; pressed[i] = 1'b0; run[i] = 0; hold[i] = 0;
      end
      exp_press = '0; exp_release = '0; exp_long = '0; exp_state = '0; exp_any = 1'b0;
    end else begin : step
      logic [NK-1:0] np, nr, nl;
      bit a;
      np = '0; nr = '0; nl = '0;
      for (int i = 0; i < NK; i++) begin
        a     = h2[i];
        h2[i] = h1[i];
        h1[i] = !key_in[i];
        if (a != pressed[i]) begin
          run[i]++;
          if (run[i] == CM) begin
            pressed[i] = a;
            run[i]     = 0;
            if (a) begin
              np[i]   = 1'b1;
              hold[i] = 0;
            end else begin
              nr[i]   = 1'b1;
            end
          end
        end else begin
          if (pressed[i] && run[i] == 0 && hold[i] < LM) begin
            hold[i]++;
            if (hold[i] == LM) nl[i] = 1'b1;
          end
          run[i] = 0;
        end
        exp_state[i] = pressed[i];
      end
      exp_press = np; exp_release = nr; exp_long = nl; exp_any = |np;
    end
  end

  always @(negedge clk) begin
    check("cyc_press_flag",   press_flag,   exp_press);
    check("cyc_release_flag", release_flag, exp_release);
    check("cyc_long_flag",    long_flag,    exp_long);
    check("cyc_key_state",    key_state,    exp_state);
    check("cyc_any_press",    any_press,    exp_any);
  end

  int cnt;

  initial begin
    #1 rst_n = 1'b0;
    cyc(2);
    #1 check("reset_outputs", {press_flag, release_flag, long_flag, key_state, any_press}, 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(3);

    // key 0 press latency, then long-press
    key_in[0] = 1'b0;
    cyc(5);
    check("t1_no_early_press", press_flag, 32'h0);
    cyc(1);
    check("t1_press", press_flag, 32'h1);
    check("t1_any", any_press, 32'h1);
    cyc(1);
    check("t1_press_gone", press_flag, 32'h0);
    check("t1_any_gone", any_press, 32'h0);
    check("t1_state", key_state, 32'h1);
    cyc(8);
    check("t3_no_early_long", long_flag, 32'h0);
    cyc(1);
    check("t3_long", long_flag, 32'h1);
    cnt = 0;
    repeat (20) begin
      cyc(1);
      if (long_flag[0]) cnt++;
    end
    check("t3_no_second_long", cnt, 32'd0);
    key_in[0] = 1'b1;
    cyc(8);
    check("t3_released", key_state, 32'h0);

    // key 1 short glitch
    key_in[1] = 1'b0;
    cyc(3);
    key_in[1] = 1'b1;
    cnt = 0;
    repeat (10) begin
      cyc(1);
      if (press_flag[1]) cnt++;
    end
    check("t2_no_press", cnt, 32'd0);
    check("t2_state", key_state[1], 32'h0);

    // key 2 release with bounce
    key_in[2] = 1'b0;
    cyc(6);
    check("t4_press", press_flag, 32'h4);
    cyc(2);
    key_in[2] = 1'b1;
    cyc(2);
    key_in[2] = 1'b0;
    cyc(2);
    key_in[2] = 1'b1;
    cnt = 0;
    repeat (5) begin
      cyc(1);
      if (release_flag[2]) cnt++;
    end
    check("t4_no_early_release", cnt, 32'd0);
    cyc(1);
    check("t4_release", release_flag, 32'h4);
    check("t4_state", key_state[2], 32'h0);
    cyc(3);

    // keys 0 and 3 together
    key_in[0] = 1'b0;
    key_in[3] = 1'b0;
    cyc(5);
    check("t5_no_early_press", press_flag, 32'h0);
    cyc(1);
    check("t5_press", press_flag, 32'h9);
    check("t5_any", any_press, 32'h1);
    cyc(1);

    // reset mid-filter on key 1
    key_in[1] = 1'b0;
    cyc(4);
    check("t6_state_before_reset", key_state, 32'h9);
    #2 rst_n = 1'b0;
    #1 check("t6_reset_outputs", {press_flag, release_flag, long_flag, key_state, any_press}, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    check("t6_no_early_press", press_flag, 32'h0);
    cyc(1);
    check("t6_press", press_flag, 32'hB);
    check("t6_any", any_press, 32'h1);
    cyc(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
Parametrised multi-channel push-button conditioner, the successor to the single-key debounce filter. It sits between raw board key pins and game/control logic. Per channel it provides:
- input synchronisation and configurable active level;
- debounced press and release pulses;
- a debounced key level;
- a one-shot long-press pulse.

Parameters:
NUM_KEYS, 4, number of independent key channels (>=1)
CNT_W, 20, width of debounce counter
CNT_MAX, 20'd999_999, consecutive stable cycles required to accept a press or release (20 ms at 50 MHz); must be >=2
LONG_W, 26, width of hold counter
LONG_MAX, 26'd49_999_999, HELD cycles before long_flag fires (1 s at 50 MHz); 0 disables long-press
ACTIVE_LOW, 1, 1: key pressed when pin=0; 0: pressed when pin=1

Ports:
clk  input  1  system clock; single clock domain
rst_n  input  1  asynchronous active-low reset
key_in  input  NUM_KEYS  raw asynchronous key pins
press_flag  output  NUM_KEYS  one-cycle pulse per accepted press
release_flag  output  NUM_KEYS  one-cycle pulse per accepted release
long_flag  output  NUM_KEYS  one-cycle pulse once per press held LONG_MAX cycles
key_state  output  NUM_KEYS  debounced level, 1 = pressed
any_press  output  1  OR of press_flag, registered same cycle as press_flag

Behaviour:
Reset:
- Async, active-low.
- All outputs 0, all channels to IDLE, all counters 0.
- Synchroniser flops reset to the inactive pin level (1 if ACTIVE_LOW).
- Reset mid-filter or mid-hold discards progress; no flag is emitted on reset release.

Synchroniser:
- 2-FF per bit.
- a = sync2 XOR ACTIVE_LOW, so a=1 means pressed.

Per-channel FSM: states IDLE, PRESS_FILT, HELD, RELEASE_FILT; cnt is CNT_W bits.
- IDLE: a=1 -> PRESS_FILT, cnt<=1; else stay, cnt<=0.
- PRESS_FILT:
  - a=0 -> IDLE, cnt<=0.
  - a=1 and cnt==CNT_MAX-1 -> HELD, press_flag<=1, key_state<=1, cnt<=0, hold<=0.
  - otherwise cnt<=cnt+1.
- HELD:
  - a=0 -> RELEASE_FILT, cnt<=1.
  - Otherwise hold<=hold+1, saturating at LONG_MAX.
  - long_flag<=1 in the cycle hold transitions LONG_MAX-1 -> LONG_MAX, only if LONG_MAX!=0.
- RELEASE_FILT:
  - a=1 -> HELD, cnt<=0; hold keeps its value, so no second long_flag.
  - a=0 and cnt==CNT_MAX-1 -> IDLE, release_flag<=1, key_state<=0, cnt<=0.
  - otherwise cnt<=cnt+1; hold frozen.

Latency:
- With key_in held active from raw edge E1, press_flag is high for exactly the cycle following rising edge E(CNT_MAX+2).
- Release is symmetric.

Flags:
- All flags are registered and default to 0 every cycle; they are never held for more than 1 cycle.
- Any glitch shorter than CNT_MAX sampled cycles restarts the filter and produces no flag.

Channel independence:
- Channels are fully independent.
- Any combination of flags across channels may assert in the same cycle.
- any_press is 1 in any cycle where at least one press_flag is 1.

Boundary cases:
- Bounce during the release filter returns to HELD with no release_flag.
- long_flag cannot fire after release is accepted.
- hold saturation prevents wrap-around on indefinite holds.
- cnt never exceeds CNT_MAX-1.

Decomposition:
- Shared package key_pkg:
  - FSM state typedef: 2-bit, IDLE=0, PRESS_FILT=1, HELD=2, RELEASE_FILT=3;
  - default timing constants for a 50 MHz clock (20 ms, 1 s).
- One sub-module key_debounce_ch:
  - single channel: synchroniser, FSM, both counters, three flags;
  - instantiated NUM_KEYS times via generate.
- The top adds only the any_press OR register.

Test Plan (CNT_MAX=4, LONG_MAX=10, NUM_KEYS=4, ACTIVE_LOW=1):
1. key_in[0] driven 0 from edge 1 and held -> press_flag[0]=1 for exactly the cycle after edge 6; key_state[0]=1 from then; any_press=1 that cycle only.
2. key_in[1] pulses 0 for 3 cycles, then 1 (bounce) -> no press_flag[1], key_state[1] stays 0, FSM back to IDLE.
3. Press key 0 and hold 20 cycles past acceptance -> exactly one long_flag[0], 10 cycles after press_flag[0]; none thereafter.
4. Accepted key 2 released, with a 2-cycle return to 0 mid-release-filter -> no release_flag; a final clean release gives release_flag[2] CNT_MAX+2 edges after the last raw edge, and key_state[2]=0.
5. Keys 0 and 3 pressed on the same edge -> press_flag=4'b1001 in one cycle; any_press=1.
6. rst_n asserted while key 1 is in PRESS_FILT with cnt=2 -> all outputs 0 immediately; after release with the key still held, press_flag[1] requires a full CNT_MAX+2 edges.
